datapath: RTL and testbench

Single-cycle (one instruction per clock) RV64 integer datapath for the sequential processor build. It integrates instruction fetch, decode, a 32×64 register file, ALU, data memory and PC update in one top-level block with no external data ports. Program and result visibility go through fixed internal signal names that the verification bench probes hierarchically. The instruction image is loaded into the fetch stage's memory before reset is released.

---
 rtl/datapath_pkg.sv | 41 ++++
 rtl/datapath_if.sv | 14 +
 rtl/if_stage.sv | 18 +
 rtl/datapath.sv | 110 +++++++++++
 tb/tb_datapath.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared constants, ALU-op encoding and immediate helpers for the single-cycle RV64 datapath.
package datapath_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned IMEM_DEPTH = 256;
    localparam int unsigned DMEM_DEPTH = 64;
    localparam int unsigned IMEM_AW    = 8;
    localparam int unsigned DMEM_AW    = 6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_LD      = 3'b011;
    localparam logic [2:0] F3_SD      = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [1:0] {ADD, SUB, AND, OR} alu_op_e;

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] ins);
        return {{52{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] ins);
        return {{52{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] ins);
        return {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/datapath_if.sv
// Fetch bus between the datapath and its instruction-memory stage (word index in, word out,
// plus a preload write port).
interface datapath_if
    import datapath_pkg::*;
();
    logic [IMEM_AW-1:0] word_idx;
    logic [31:0]        instr;
    logic               load_en;
    logic [IMEM_AW-1:0] load_addr;
    logic [31:0]        load_data;

    modport master (output word_idx, load_en, load_addr, load_data, input instr);
    modport slave  (input word_idx, load_en, load_addr, load_data, output instr);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns instr_mem and returns the word selected by the fetch index.
module if_stage
    import datapath_pkg::*;
(
    input logic       clock,
    datapath_if.slave fetch
);
    logic [31:0] instr_mem [0:IMEM_DEPTH-1];

    // Never cleared by reset; the image is normally placed here before reset is released.
    always_ff @(posedge clock) begin
        if (fetch.load_en) begin
            instr_mem[fetch.load_addr] <= fetch.load_data;
        end
    end

    assign fetch.instr = instr_mem[fetch.word_idx];
endmodule

// File: rtl/datapath.sv
// Single-cycle RV64 integer datapath: fetch, decode, register file, ALU, data memory, PC update.
// Define DATAPATH_TRACE_EN to print one execution-trace line per cycle in simulation.
module datapath
    import datapath_pkg::*;
(
    input logic clock,
    input logic reset
);
    logic [XLEN-1:0]    PC;
    logic [XLEN-1:0]    pc_d;
    logic [XLEN-1:0]    register    [0:31];
    logic [XLEN-1:0]    data_memory [0:DMEM_DEPTH-1];
    logic [31:0]        instr;
    logic [6:0]         opcode, funct7;
    logic [2:0]         funct3;
    logic [4:0]         rs1, rs2, write_addr;
    logic [XLEN-1:0]    rd1, rd2, wd, alu_output, alu_b, imm;
    logic               is_r, is_addi, is_ld, is_sd, is_beq, zero, reg_we, mem_we;
    logic [DMEM_AW-1:0] mem_index;
    alu_op_e            alu_op;

    datapath_if fetch_bus ();

    assign fetch_bus.word_idx  = PC[9:2];
    assign fetch_bus.load_en   = 1'b0;
    assign fetch_bus.load_addr = '0;
    assign fetch_bus.load_data = '0;
    assign instr               = fetch_bus.instr;

    if_stage IF_stage (
        .clock (clock),
        .fetch (fetch_bus)
    );

    always_comb begin
        opcode     = instr[6:0];
        funct3     = instr[14:12];
        funct7     = instr[31:25];
        rs1        = instr[19:15];
        rs2        = instr[24:20];
        write_addr = instr[11:7];
        rd1        = (rs1 == 5'd0) ? '0 : register[rs1];
        rd2        = (rs2 == 5'd0) ? '0 : register[rs2];

        is_r    = (opcode == OP_R) &&
                  ((funct3 == F3_ADD_SUB && (funct7 == F7_ADD || funct7 == F7_SUB)) ||
                   funct3 == F3_AND || funct3 == F3_OR);
        is_addi = (opcode == OP_IMM)    && (funct3 == F3_ADDI);
        is_ld   = (opcode == OP_LOAD)   && (funct3 == F3_LD);
        is_sd   = (opcode == OP_STORE)  && (funct3 == F3_SD);
        is_beq  = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);

        alu_op = ADD;
        if (is_beq || (is_r && funct3 == F3_ADD_SUB && funct7 == F7_SUB)) begin
            alu_op = SUB;
        end else if (is_r && funct3 == F3_AND) begin
            alu_op = AND;
        end else if (is_r && funct3 == F3_OR) begin
            alu_op = OR;
        end

        imm   = is_sd ? imm_s(instr) : imm_i(instr);
        alu_b = (is_r || is_beq) ? rd2 : imm;

        unique case (alu_op)
            ADD: alu_output = rd1 + alu_b;
            SUB: alu_output = rd1 - alu_b;
            AND: alu_output = rd1 & alu_b;
            OR:  alu_output = rd1 | alu_b;
        endcase

        zero      = (alu_output == '0);
        mem_index = alu_output[8:3];
        wd        = is_ld ? data_memory[mem_index] : alu_output;
        reg_we    = (is_r || is_addi || is_ld) && (write_addr != 5'd0);
        mem_we    = is_sd;
        pc_d      = (is_beq && zero) ? PC + imm_b(instr) : PC + 64'd4;
    end

    // Reset wins over any write of the instruction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            PC <= '0;
            for (int i = 0; i < 32; i++) begin
                register[i] <= '0;
            end
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                data_memory[i] <= '0;
            end
        end else begin
            PC <= pc_d;
            if (reg_we) begin
                register[write_addr] <= wd;
            end
            if (mem_we) begin
                data_memory[mem_index] <= rd2;
            end
        end
    end

`ifdef DATAPATH_TRACE_EN
    always @(posedge clock) begin
        if (!reset) begin
            $display("PC=%0h rs1=%0d rs2=%0d rd1=%0h rd2=%0h alu=%0d wd=%0d wa=%0d idx=%0d reg=%0h mem=%0h",
                     PC, rs1, rs2, rd1, rd2, $signed(alu_output), $signed(wd), write_addr,
                     mem_index, register[write_addr], data_memory[mem_index]);
        end
    end
`endif
endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed program, mid-program reset and random programs against an ISS.
module tb_datapath;
    logic clk;
    logic reset;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] m_pc;
    logic [63:0] m_reg  [0:31];
    logic [63:0] m_mem  [0:63];
    logic [31:0] m_prog [0:255];

    datapath dut (
        .clock (clk),
        .reset (reset)
    );

    datapath_if probe ();
    assign probe.word_idx  = dut.PC[9:2];
    assign probe.instr     = dut.instr;
    assign probe.load_en   = 1'b0;
    assign probe.load_addr = '0;
    assign probe.load_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        logic [6:0] a = f7[6:0];
        logic [4:0] b = rs2[4:0];
        logic [4:0] c = rs1[4:0];
        logic [2:0] d = f3[2:0];
        logic [4:0] e = rd[4:0];
        return {a, b, c, d, e, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [11:0] a = imm[11:0];
        logic [4:0]  c = rs1[4:0];
        logic [2:0]  d = f3[2:0];
        logic [4:0]  e = rd[4:0];
        return {a, c, d, e, op};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [11:0] a = imm[11:0];
        logic [4:0]  b = rs2[4:0];
        logic [4:0]  c = rs1[4:0];
        return {a[11:5], b, c, 3'b011, a[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
        logic [12:0] a = imm[12:0];
        logic [4:0]  b = rs2[4:0];
        logic [4:0]  c = rs1[4:0];
        return {a[12], a[10:5], b, c, 3'b000, a[4:1], a[11], 7'h63};
    endfunction

    function automatic logic [63:0] sx(logic [11:0] v);
        return 64'($signed(v));
    endfunction

    // Instruction-set level reference: one architectural step from the current model state.
    task automatic model_step();
        logic [31:0] ins;
        logic [63:0] a, b, res, addr, nxt;
        logic [12:0] boff;
        logic        wr;
        int          rd;
        ins  = m_prog[m_pc[9:2]];
        a    = m_reg[ins[19:15]];
        b    = m_reg[ins[24:20]];
        rd   = int'(ins[11:7]);
        nxt  = m_pc + 64'd4;
        wr   = 1'b0;
        res  = '0;
        boff = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h00) begin
            res = a + b; wr = 1'b1;
        end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h20) begin
            res = a - b; wr = 1'b1;
        end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd7) begin
            res = a & b; wr = 1'b1;
        end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd6) begin
            res = a | b; wr = 1'b1;
        end else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
            res = a + sx(ins[31:20]); wr = 1'b1;
        end else if (ins[6:0] == 7'h03 && ins[14:12] == 3'd3) begin
            addr = a + sx(ins[31:20]);
            res  = m_mem[(addr / 8) % 64]; wr = 1'b1;
        end else if (ins[6:0] == 7'h23 && ins[14:12] == 3'd3) begin
            addr = a + sx({ins[31:25], ins[11:7]});
            m_mem[(addr / 8) % 64] = b;
        end else if (ins[6:0] == 7'h63 && ins[14:12] == 3'd0 && a == b) begin
            nxt = m_pc + 64'($signed(boff));
        end
        if (wr && rd != 0) m_reg[rd] = res;
        m_pc = nxt;
    endtask

    task automatic load_word(input int idx, input logic [31:0] w);
        m_prog[idx] = w;
        dut.IF_stage.instr_mem[idx] = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
    endtask

    task automatic step_check(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check(tag, dut.PC, m_pc);
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.register[i], m_reg[i]);
        for (int i = 0; i < 64; i++) check($sformatf("%s_m%0d", tag, i), dut.data_memory[i], m_mem[i]);
    endtask

    function automatic logic [31:0] rand_instr();
        int k  = int'($urandom_range(0, 9));
        int rd = int'($urandom_range(0, 7));
        int a  = int'($urandom_range(0, 7));
        int b  = int'($urandom_range(0, 7));
        case (k)
            0:       return enc_r(0, b, a, 0, rd);
            1:       return enc_r(32, b, a, 0, rd);
            2:       return enc_r(0, b, a, 7, rd);
            3:       return enc_r(0, b, a, 6, rd);
            4, 5:    return enc_i(int'($urandom_range(0, 4095)) - 2048, a, 0, rd, 7'h13);
            6:       return enc_i(int'($urandom_range(0, 600)), a, 3, rd, 7'h03);
            7:       return enc_s(int'($urandom_range(0, 600)), b, a);
            8:       return enc_b((int'($urandom_range(0, 12)) - 4) * 2, b, a);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 256; i++) load_word(i, 32'h0000_0013);
        load_word(0,  enc_i(5, 0, 0, 1, 7'h13));
        load_word(1,  enc_i(-3, 0, 0, 2, 7'h13));
        load_word(2,  enc_r(0, 2, 1, 0, 3));
        load_word(3,  enc_r(32, 2, 1, 0, 4));
        load_word(4,  enc_r(0, 2, 1, 7, 5));
        load_word(5,  enc_r(0, 2, 1, 6, 6));
        load_word(6,  enc_s(16, 1, 0));
        load_word(7,  enc_i(16, 0, 3, 7, 7'h03));
        load_word(8,  enc_i(23, 0, 3, 8, 7'h03));
        load_word(9,  enc_i(7, 0, 0, 0, 7'h13));
        load_word(10, enc_b(8, 1, 1));
        load_word(11, enc_i(1, 0, 0, 9, 7'h13));
        load_word(12, enc_b(8, 2, 1));
        load_word(13, 32'hFFFF_FFFF);
        load_word(14, enc_b(0, 0, 0));

        do_reset();
        check("reset_pc", dut.PC, 64'd0);
        compare_all("reset");

        step_check("pc_addi1");
        step_check("pc_addi2");
        check("x1_5", dut.register[1], 64'd5);
        check("x2_m3", dut.register[2], 64'hFFFF_FFFF_FFFF_FFFD);
        check("pc_8", dut.PC, 64'd8);
        for (int i = 0; i < 11; i++) begin
            check("fetch", probe.instr, m_prog[m_pc[9:2]]);
            if (m_pc == 64'd28) begin
                check("ld_wd", dut.wd, 64'd5);
                check("ld_alu", dut.alu_output, 64'd16);
            end
            step_check("pc_dir");
        end
        check("x3_add", dut.register[3], 64'd2);
        check("x4_sub", dut.register[4], 64'd8);
        check("x5_and", dut.register[5], 64'd5);
        check("x6_or", dut.register[6], 64'hFFFF_FFFF_FFFF_FFFD);
        check("mem2_sd", dut.data_memory[2], 64'd5);
        check("x7_ld", dut.register[7], 64'd5);
        check("x8_ld_lowbits", dut.register[8], 64'd5);
        check("x0_zero", dut.register[0], 64'd0);
        check("x9_skipped", dut.register[9], 64'd0);
        check("pc_halt", dut.PC, 64'd56);
        for (int i = 0; i < 3; i++) step_check("pc_hold");
        check("pc_still_56", dut.PC, 64'd56);
        compare_all("dir");

        load_word(0, enc_i(5, 0, 0, 1, 7'h13));
        load_word(1, enc_s(16, 1, 0));
        load_word(2, enc_i(9, 0, 0, 3, 7'h13));
        do_reset();
        step_check("rb_pc1");
        step_check("rb_pc2");
        check("rb_x1", dut.register[1], 64'd5);
        check("rb_mem2", dut.data_memory[2], 64'd5);
        do_reset();
        check("rb_pc0", dut.PC, 64'd0);
        check("rb_x1_clr", dut.register[1], 64'd0);
        check("rb_mem2_clr", dut.data_memory[2], 64'd0);
        check("rb_x3_drop", dut.register[3], 64'd0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) load_word(i, rand_instr());
            do_reset();
            for (int c = 0; c < 300; c++) step_check("rnd_pc");
            compare_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
